// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory address/data, branch redirect, and the
// {pc, instr} decode handshake. The master modport is the fetch queue itself.
interface if_fetch_queue_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  im_addr;
  logic [0:INSTR_W-1] im_dout;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  // Handshake: an entry moves to decode on a cycle where id_valid & id_ready.
  // While id_valid is high and id_ready is low, id_pc/id_instr hold steady.
  // id_valid never depends on id_ready.
  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc;
  logic [0:INSTR_W-1] id_instr;

  modport master (
    output im_addr, id_valid, id_pc, id_instr,
    input  im_dout, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  im_addr, id_valid, id_pc, id_instr,
    output im_dout, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: fetch PC, zero-latency memory capture into a
// small FIFO, decode handshake, redirect flush. Optional IF_PERF_CNT_EN adds counters.
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_3000),
  parameter int                QDEPTH   = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
`endif
  if_fetch_queue_if.master bus
);
  localparam int              PTR_W    = $clog2(QDEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(QDEPTH);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     count;
  logic [ADDR_W-1:0]  pc_mem    [QDEPTH];
  logic [0:INSTR_W-1] instr_mem [QDEPTH];
  logic               id_valid;
  logic               redirect;
  logic               deq;
  logic               enq;

  assign redirect = bus.redirect_valid;
  assign id_valid = (count != '0);
  assign deq      = id_valid & bus.id_ready;
  // A full queue can still accept when the head leaves in the same cycle.
  assign enq      = ~redirect & ((count < FULL_CNT) | deq);

  assign bus.im_addr  = fetch_pc;
  assign bus.id_valid = id_valid;
  assign bus.id_pc    = pc_mem[rd_ptr];
  assign bus.id_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (enq) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.im_dout;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating event counters; they never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (enq && perf_fetch != 32'hFFFF_FFFF) perf_fetch <= perf_fetch + 32'd1;
      if (!redirect && !enq && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
      if (redirect && perf_flush != 32'hFFFF_FFFF) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_if_fetch_queue;
  localparam int          ADDR_W   = 32;
  localparam int          INSTR_W  = 32;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  if_fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  if_fetch_queue #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef IF_PERF_CNT_EN
    .perf_fetch(perf_fetch),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush),
`endif
    .bus(bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction memory: a fixed, address-dependent pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always_comb bus.im_dout = mem_word(bus.im_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: expected queue of PCs plus the expected fetch PC
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;

  task automatic model_reset();
    exp_q.delete();
    m_pc = RESET_PC;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 32'(bus.id_valid), 32'(exp_q.size() > 0));
    check({tag, "_im_addr"}, bus.im_addr, m_pc);
    if (exp_q.size() > 0) begin
      check({tag, "_id_pc"}, bus.id_pc, exp_q[0]);
      check({tag, "_id_instr"}, bus.id_instr, mem_word(exp_q[0]));
    end
  endtask

  // driver: apply inputs for one cycle, step the model, land on the next negedge
  task automatic drive_cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.id_ready       = rdy;
    if (rv) begin
      exp_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() < QDEPTH) begin
        exp_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_ia;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] ia,
                              input logic rv, input logic [31:0] rpc, input logic rdy);
    vec_t t;
    t.exp_v = v; t.exp_pc = pc; t.exp_ia = ia; t.rv = rv; t.rpc = rpc; t.rdy = rdy;
    return t;
  endfunction

  vec_t vecs[17];

  initial begin
    // expected outputs sampled before each cycle's inputs are applied
    vecs[0]  = mk(0, 32'h0,         32'h3000,      0, 32'h0,         1);
    vecs[1]  = mk(1, 32'h3000,      32'h3004,      0, 32'h0,         1);
    vecs[2]  = mk(1, 32'h3004,      32'h3008,      0, 32'h0,         1);
    vecs[3]  = mk(1, 32'h3008,      32'h300C,      0, 32'h0,         0);
    vecs[4]  = mk(1, 32'h3008,      32'h3010,      0, 32'h0,         0);
    vecs[5]  = mk(1, 32'h3008,      32'h3014,      0, 32'h0,         0);
    vecs[6]  = mk(1, 32'h3008,      32'h3018,      0, 32'h0,         0);
    vecs[7]  = mk(1, 32'h3008,      32'h3018,      0, 32'h0,         1);
    vecs[8]  = mk(1, 32'h300C,      32'h301C,      0, 32'h0,         1);
    vecs[9]  = mk(1, 32'h3010,      32'h3020,      1, 32'h4002,      1);
    vecs[10] = mk(0, 32'h0,         32'h4000,      0, 32'h0,         1);
    vecs[11] = mk(1, 32'h4000,      32'h4004,      1, 32'h5000,      0);
    vecs[12] = mk(0, 32'h0,         32'h5000,      1, 32'hFFFF_FFFA, 1);
    vecs[13] = mk(0, 32'h0,         32'hFFFF_FFF8, 0, 32'h0,         1);
    vecs[14] = mk(1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 32'h0,         1);
    vecs[15] = mk(1, 32'hFFFF_FFFC, 32'h0,         0, 32'h0,         1);
    vecs[16] = mk(1, 32'h0,         32'h4,         0, 32'h0,         1);

    // table run from reset: streaming, fill/stall, full enq+deq, redirects, PC wrap
    do_reset();
    check("rst_id_pc", bus.id_pc, 32'h0);
    check("rst_id_instr", bus.id_instr, 32'h0);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("vec%0d_valid", i), 32'(bus.id_valid), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_im_addr", i), bus.im_addr, vecs[i].exp_ia);
      if (vecs[i].exp_v) begin
        check($sformatf("vec%0d_id_pc", i), bus.id_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_id_instr", i), bus.id_instr, mem_word(vecs[i].exp_pc));
      end
      drive_cycle(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
    end

    // decode stalled 10 cycles from reset: exactly QDEPTH entries, head stable
    do_reset();
`ifdef IF_PERF_CNT_EN
    check("rst_perf_fetch", perf_fetch, 32'h0);
    check("rst_perf_stall", perf_stall, 32'h0);
    check("rst_perf_flush", perf_flush, 32'h0);
`endif
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b0);
      check("stall_valid", 32'(bus.id_valid), 32'h1);
      check("stall_id_pc", bus.id_pc, 32'h3000);
    end
    check("stall_im_addr", bus.im_addr, 32'h3010);
`ifdef IF_PERF_CNT_EN
    check("stall_perf_stall", perf_stall, 32'd6);
    check("stall_perf_fetch", perf_fetch, 32'd4);
    check("stall_perf_flush", perf_flush, 32'd0);
`endif
    for (int k = 0; k < 5; k++) begin
      check("release_id_pc", bus.id_pc, 32'h3000 + 32'(4 * k));
      drive_cycle(1'b0, 32'h0, 1'b1);
    end

    // asynchronous reset between edges with two entries queued
    do_reset();
    drive_cycle(1'b0, 32'h0, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b0);
    check("pre_areset_id_pc", bus.id_pc, 32'h3000);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(bus.id_valid), 32'h0);
    check("areset_im_addr", bus.im_addr, 32'h3000);
    check("areset_id_pc", bus.id_pc, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("areset_perf_fetch", perf_fetch, 32'h0);
    check("areset_perf_stall", perf_stall, 32'h0);
`endif

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      check_model("rand");
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rdy = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      drive_cycle(rv, rpc, rdy);
    end
    check_model("rand_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
